grid_access_arbiter: RTL
========================

Name: grid_access_arbiter

Overview:
Sole owner of the grid cell memory (GRID_SIZE_X x GRID_SIZE_Y cells, 4-bit cell codes NULL/SNAKE/ROCK/SNACK). It shares the single-port synchronous RAM between two requesters. Port A is the game controller, which reads and writes cells. Port B is the renderer, which only reads. Round-robin arbitration decides between them. A built-in clear sequencer fills the grid with CLEAR_CODE after reset or on request. Coordinates are translated to linear addresses here, and out-of-range cells read back as OOB_CODE, so game logic sees the border as an obstacle.

Parameters:
GRID_SIZE_X, 32, cells per row (x width 5 bits)
GRID_SIZE_Y, 24, rows (y width 5 bits)
ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= GRID_SIZE_X*GRID_SIZE_Y
OOB_CODE, 4'b0010, code returned for reads with x>=GRID_SIZE_X or y>=GRID_SIZE_Y (ROCK)
CLEAR_CODE, 4'b0000, code written by clear sequencer (NULL)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
clear_req  in  1  one-cycle pulse: refill grid with CLEAR_CODE
ready  out  1  high when serving requests (not clearing)
a_req  in  1  port A request, held until a_gnt
a_we  in  1  port A: 1 = write, 0 = read
a_x  in  5  port A cell x
a_y  in  5  port A cell y
a_wdata  in  4  port A write code
a_gnt  out  1  port A grant pulse
a_rvalid  out  1  port A read data valid pulse
a_rdata  out  4  port A read data
b_req  in  1  port B read request, held until b_gnt
b_x  in  5  port B cell x
b_y  in  5  port B cell y
b_gnt  out  1  port B grant pulse
b_rvalid  out  1  port B read data valid pulse
b_rdata  out  4  port B read data
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  4  RAM write data
mem_rdata  in  4  RAM read data, valid one cycle after address is sampled

Behaviour:
- Reset (rst low at a clk edge): all outputs 0, state CLEAR, clear counter 0, RR pointer = B (A wins first tie), read pipeline flushed (no rvalid from pre-reset grants).
- States: CLEAR and SERVE.
  - CLEAR: each cycle mem_we=1, mem_addr=counter, mem_wdata=CLEAR_CODE; counter increments 0..GRID_SIZE_X*GRID_SIZE_Y-1. After the last address, go to SERVE and set ready=1 (registered).
  - SERVE: clear_req=1 means go to CLEAR next cycle, with counter=0 and ready=0. Any request sampled in the same cycle is not granted.
  - No grants are issued in CLEAR. clear_req during CLEAR is ignored.
  - In-flight reads still deliver rvalid across a SERVE->CLEAR transition.
- Arbitration happens in SERVE, sampled in cycle t:
  - Eligible means req=1 and that port's gnt is not high in cycle t. This prevents a double grant while the requester drops req.
  - If both ports are eligible, grant the port not last granted.
  - If one port is eligible, grant it.
  - The RR pointer updates only on a grant.
- Timing, all registered:
  - gnt pulse and mem_addr/mem_we/mem_wdata are visible in cycle t+1.
  - The RAM samples at the end of t+1 and mem_rdata is valid in t+2.
  - rdata and rvalid are visible in t+3 for reads only, with rvalid as a one-cycle pulse. Write grants produce no rvalid.
- Address: mem_addr = y*GRID_SIZE_X + x, truncated to ADDR_W.
- Out of range (x>=GRID_SIZE_X or y>=GRID_SIZE_Y):
  - The grant is issued normally.
  - mem_we is forced to 0.
  - A read returns OOB_CODE with rvalid at t+3, and mem_rdata is ignored.
- When there is no grant and the state is not CLEAR: mem_we=0, and mem_addr/mem_wdata hold their previous values.
- Max throughput: one grant per cycle overall; one grant per 2 cycles per port.
- Read pipeline tags each slot with port ID and OOB flag, so up to 2 reads are in flight.

Test Plan:
- Release rst -> exactly 768 consecutive cycles with mem_we=1, addresses 0..767, wdata 0. ready rises the cycle after addr 767. Requests held during clear get no gnt until ready=1.
- A writes (x=5,y=3,wdata=4'b0100) then reads the same cell -> mem_addr=101 with we=1. The read returns a_rdata=4'b0100 with a_rvalid exactly 3 cycles after the read request is sampled.
- a_req and b_req both held high continuously -> grants alternate A,B,A,B starting with A. No port is granted in two consecutive cycles. b_rvalid never asserts for A's reads.
- A reads (x=0,y=24) and A writes (x=31,y=30) -> both granted, mem_we stays 0. The read returns a_rdata=4'b0010.
- Pulse clear_req with a B read granted the previous cycle -> b_rvalid is still delivered, ready drops, and 768 clear writes follow. Re-pulsing clear_req mid-clear does not restart the count.
- Drive rst low mid-clear at counter 300 -> outputs 0. After release, clear restarts at address 0 and all 768 writes occur.

Source files
------------

// File: rtl/grid_access_arbiter_if.sv
// Requester-side bundle for the grid arbiter: game port A (read/write)
// and renderer port B (read only).
interface grid_access_arbiter_if;
    logic       a_req;
    logic       a_we;
    logic [4:0] a_x;
    logic [4:0] a_y;
    logic [3:0] a_wdata;
    logic       a_gnt;
    logic       a_rvalid;
    logic [3:0] a_rdata;
    logic       b_req;
    logic [4:0] b_x;
    logic [4:0] b_y;
    logic       b_gnt;
    logic       b_rvalid;
    logic [3:0] b_rdata;

    modport master (
        output a_req, a_we, a_x, a_y, a_wdata, b_req, b_x, b_y,
        input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_x, a_y, a_wdata, b_req, b_x, b_y,
        output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/grid_access_arbiter.sv
// Owns the grid cell RAM: round-robin A/B access, coordinate translation,
// out-of-range reads as OOB_CODE, and a clear sequencer.
module grid_access_arbiter #(
    parameter int         GRID_SIZE_X = 32,
    parameter int         GRID_SIZE_Y = 24,
    parameter int         ADDR_W      = 10,
    parameter logic [3:0] OOB_CODE    = 4'b0010,
    parameter logic [3:0] CLEAR_CODE  = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  ready,
    grid_access_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_wdata,
    input  logic [3:0]            mem_rdata
);
    localparam int CELLS = GRID_SIZE_X * GRID_SIZE_Y;
    localparam int CW    = ADDR_W + 1;

    typedef enum logic {CLEAR, SERVE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last_b;
    logic            p1_v, p1_b, p1_oob;
    logic            p2_v, p2_b, p2_oob;

    logic            a_el, b_el, pick_a, pick_b;
    logic [4:0]      sel_x, sel_y;
    logic            sel_we, sel_oob;
    logic [ADDR_W-1:0] sel_addr;

    function automatic logic is_oob(input logic [4:0] x, input logic [4:0] y);
        return (32'(x) >= 32'(GRID_SIZE_X)) || (32'(y) >= 32'(GRID_SIZE_Y));
    endfunction

    function automatic logic [ADDR_W-1:0] lin(input logic [4:0] x, input logic [4:0] y);
        return ADDR_W'(32'(y) * 32'(GRID_SIZE_X) + 32'(x));
    endfunction

    // A port whose grant is showing this cycle is ignored so a held req
    // is not granted twice while the requester drops it.
    always_comb begin
        a_el     = bus.a_req && !bus.a_gnt;
        b_el     = bus.b_req && !bus.b_gnt;
        pick_a   = a_el && (!b_el || last_b);
        pick_b   = b_el && !pick_a;
        sel_x    = pick_a ? bus.a_x : bus.b_x;
        sel_y    = pick_a ? bus.a_y : bus.b_y;
        sel_we   = pick_a && bus.a_we;
        sel_oob  = is_oob(sel_x, sel_y);
        sel_addr = lin(sel_x, sel_y);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= CLEAR;
            cnt          <= '0;
            last_b       <= 1'b1;
            ready        <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            bus.a_gnt    <= 1'b0;
            bus.b_gnt    <= 1'b0;
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
            bus.a_rdata  <= '0;
            bus.b_rdata  <= '0;
            p1_v         <= 1'b0;
            p1_b         <= 1'b0;
            p1_oob       <= 1'b0;
            p2_v         <= 1'b0;
            p2_b         <= 1'b0;
            p2_oob       <= 1'b0;
        end else begin
            bus.a_gnt    <= 1'b0;
            bus.b_gnt    <= 1'b0;
            p1_v         <= 1'b0;
            p2_v         <= p1_v;
            p2_b         <= p1_b;
            p2_oob       <= p1_oob;
            bus.a_rvalid <= p2_v && !p2_b;
            bus.b_rvalid <= p2_v && p2_b;
            if (p2_v && !p2_b)
                bus.a_rdata <= p2_oob ? OOB_CODE : mem_rdata;
            if (p2_v && p2_b)
                bus.b_rdata <= p2_oob ? OOB_CODE : mem_rdata;

            unique case (state)
                CLEAR: begin
                    if (cnt == CW'(CELLS)) begin
                        state  <= SERVE;
                        ready  <= 1'b1;
                        mem_we <= 1'b0;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt[ADDR_W-1:0];
                        mem_wdata <= CLEAR_CODE;
                        cnt       <= cnt + 1'b1;
                    end
                end
                SERVE: begin
                    mem_we <= 1'b0;
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end else if (pick_a || pick_b) begin
                        bus.a_gnt <= pick_a;
                        bus.b_gnt <= pick_b;
                        last_b    <= pick_b;
                        mem_addr  <= sel_addr;
                        mem_we    <= sel_we && !sel_oob;
                        if (pick_a)
                            mem_wdata <= bus.a_wdata;
                        p1_v      <= !sel_we;
                        p1_b      <= pick_b;
                        p1_oob    <= sel_oob;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
